key_event_fifo: RTL and testbench



---
 rtl/key_event_pkg.sv | 14 +
 rtl/key_fifo.sv | 68 ++++++
 rtl/key_event_fifo.sv | 122 ++++++++++++
 tb/tb_key_event_fifo.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// Shared types for the keypad event path:
// debounce FSM states and key code width.
package key_event_pkg;

  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_REL_WAIT
  } deb_state_e;

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO for key events.
// Accepts a push when full only if a pop happens in the same cycle.
module key_fifo
  import key_event_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = KEY_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the read port is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/key_event_fifo.sv
// Debounces scanner key-down levels into one event per stable
// press and queues the events behind a valid/ready handshake.
module key_event_fifo
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2000,
  parameter int DEPTH           = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [KEY_W-1:0]         key_in,
  input  logic                     pressed_in,
  output logic                     ev_valid,
  output logic [KEY_W-1:0]         ev_key,
  input  logic                     ev_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DC = CW'(DEBOUNCE_CYCLES);

  deb_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic             ovf_q, ovf_d;
  logic             push;
  logic             drop;
  logic             full;
  logic             empty;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    push    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pressed_in) begin
          cand_d  = key_in;
          cnt_d   = CW'(1);
          state_d = ST_PRESS_WAIT;
        end
      end
      ST_PRESS_WAIT: begin
        if (!pressed_in) begin
          state_d = ST_IDLE;
        end else if (key_in != cand_q) begin
          cand_d = key_in;
          cnt_d  = CW'(1);
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == DC) begin
            push    = 1'b1;
            state_d = ST_HELD;
          end
        end
      end
      ST_HELD: begin
        if (!pressed_in) begin
          cnt_d   = CW'(1);
          state_d = ST_REL_WAIT;
        end
      end
      ST_REL_WAIT: begin
        if (pressed_in) begin
          state_d = ST_HELD;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == DC) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A full FIFO still takes the push when the head leaves this cycle.
  assign drop = push && full && !ev_ready;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      ovf_q   <= ovf_d;
    end
  end

  key_fifo #(
    .DEPTH (DEPTH),
    .W     (KEY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (cand_q),
    .pop       (ev_ready),
    .pop_data  (ev_key),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  assign ev_valid = !empty;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_key_event_fifo.sv
// Directed bench for key_event_fifo with DEBOUNCE_CYCLES=4,
// DEPTH=4; inputs change and outputs are sampled 1ns after posedge.
module tb_key_event_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in;
  logic       pressed_in;
  logic       ev_valid;
  logic [3:0] ev_key;
  logic       ev_ready;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_event_fifo #(
    .DEBOUNCE_CYCLES (4),
    .DEPTH           (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .pressed_in (pressed_in),
    .ev_valid   (ev_valid),
    .ev_key     (ev_key),
    .ev_ready   (ev_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press_release(input logic [3:0] k);
    pressed_in = 1'b1;
    key_in     = k;
    repeat (4) tick();
    pressed_in = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    key_in     = 4'h0;
    pressed_in = 1'b0;
    ev_ready   = 1'b0;
    ovf_clr    = 1'b0;
    repeat (2) tick();
    chk("rst_valid", 8'(ev_valid), 8'h0);
    chk("rst_key", 8'(ev_key), 8'h0);
    chk("rst_count", 8'(fifo_count), 8'h0);
    chk("rst_ovf", 8'(overflow), 8'h0);
    rst_n = 1'b1;

    // clean press, key 7
    pressed_in = 1'b1;
    key_in     = 4'h7;
    repeat (3) tick();
    chk("clean_early", 8'(ev_valid), 8'h0);
    tick();
    chk("clean_valid", 8'(ev_valid), 8'h1);
    chk("clean_key", 8'(ev_key), 8'h7);
    chk("clean_count", 8'(fifo_count), 8'h1);
    repeat (6) tick();
    chk("clean_once", 8'(fifo_count), 8'h1);
    pressed_in = 1'b0;
    repeat (4) tick();
    ev_ready = 1'b1;
    tick();
    chk("clean_pop_cnt", 8'(fifo_count), 8'h0);
    chk("clean_pop_key", 8'(ev_key), 8'h0);
    tick();
    chk("ready_empty", 8'(fifo_count), 8'h0);
    ev_ready = 1'b0;

    // bounce on key 2
    key_in = 4'h2;
    pressed_in = 1'b1; tick();
    pressed_in = 1'b0; tick();
    pressed_in = 1'b1; tick();
    tick();
    pressed_in = 1'b0; tick();
    chk("bounce_none", 8'(ev_valid), 8'h0);
    pressed_in = 1'b1;
    repeat (3) tick();
    chk("bounce_early", 8'(ev_valid), 8'h0);
    tick();
    chk("bounce_key", 8'(ev_key), 8'h2);
    chk("bounce_count", 8'(fifo_count), 8'h1);
    repeat (3) tick();
    pressed_in = 1'b0;
    repeat (4) tick();
    chk("bounce_once", 8'(fifo_count), 8'h1);
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;

    // key change 3 -> 5 during press wait
    pressed_in = 1'b1;
    key_in     = 4'h3;
    repeat (2) tick();
    key_in = 4'h5;
    repeat (3) tick();
    chk("chg_early", 8'(ev_valid), 8'h0);
    tick();
    chk("chg_key", 8'(ev_key), 8'h5);
    chk("chg_count", 8'(fifo_count), 8'h1);
    pressed_in = 1'b0;
    repeat (2) tick();
    pressed_in = 1'b1;
    repeat (3) tick();
    key_in = 4'h6;
    repeat (3) tick();
    pressed_in = 1'b0;
    repeat (4) tick();
    chk("glitch_once", 8'(fifo_count), 8'h1);
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    chk("glitch_drain", 8'(fifo_count), 8'h0);

    // overflow with keys 1..5
    press_release(4'h1);
    press_release(4'h2);
    press_release(4'h3);
    press_release(4'h4);
    chk("full_count", 8'(fifo_count), 8'h4);
    chk("full_no_ovf", 8'(overflow), 8'h0);
    press_release(4'h5);
    chk("ovf_count", 8'(fifo_count), 8'h4);
    chk("ovf_set", 8'(overflow), 8'h1);
    chk("ovf_head", 8'(ev_key), 8'h1);
    ev_ready = 1'b1;
    tick(); chk("ovf_pop2", 8'(ev_key), 8'h2);
    tick(); chk("ovf_pop3", 8'(ev_key), 8'h3);
    tick(); chk("ovf_pop4", 8'(ev_key), 8'h4);
    tick();
    chk("ovf_empty", 8'(ev_valid), 8'h0);
    chk("ovf_sticky", 8'(overflow), 8'h1);
    ev_ready = 1'b0;
    ovf_clr  = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", 8'(overflow), 8'h0);

    // full with simultaneous push of 9 and pop
    press_release(4'h1);
    press_release(4'h2);
    press_release(4'h3);
    press_release(4'h4);
    pressed_in = 1'b1;
    key_in     = 4'h9;
    repeat (3) tick();
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    chk("pp_count", 8'(fifo_count), 8'h4);
    chk("pp_no_ovf", 8'(overflow), 8'h0);
    chk("pp_head", 8'(ev_key), 8'h2);
    pressed_in = 1'b0;
    repeat (4) tick();
    ev_ready = 1'b1;
    tick(); chk("pp_pop3", 8'(ev_key), 8'h3);
    tick(); chk("pp_pop4", 8'(ev_key), 8'h4);
    tick(); chk("pp_pop9", 8'(ev_key), 8'h9);
    tick(); chk("pp_empty", 8'(fifo_count), 8'h0);
    ev_ready = 1'b0;

    // reset with 2 queued and FSM in press wait
    press_release(4'hA);
    press_release(4'hB);
    chk("pre_rst_count", 8'(fifo_count), 8'h2);
    pressed_in = 1'b1;
    key_in     = 4'hC;
    repeat (2) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mid_rst_valid", 8'(ev_valid), 8'h0);
    chk("mid_rst_key", 8'(ev_key), 8'h0);
    chk("mid_rst_count", 8'(fifo_count), 8'h0);
    chk("mid_rst_ovf", 8'(overflow), 8'h0);
    repeat (3) tick();
    chk("post_rst_early", 8'(ev_valid), 8'h0);
    tick();
    chk("post_rst_key", 8'(ev_key), 8'hC);
    chk("post_rst_count", 8'(fifo_count), 8'h1);
    pressed_in = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
